// File: rtl/img_processing_pkg.sv
// Shared image-pipeline constants and types.
// The frame arbiter's state type and source limit live here as well.
package img_processing_pkg;

  localparam int IMG_W            = 8;
  localparam int IMG_H            = 4;
  localparam int AXIS_TDATA_WIDTH = 8;
  localparam int AXIS_TUSER_WIDTH = 1;

  localparam int ARB_MAX_SRC = 8;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_STREAM
  } arb_state_t;

  // Index of the set bit of a one-hot vector; 0 when the vector is empty.
  function automatic int unsigned onehot_to_idx(input logic [ARB_MAX_SRC-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < ARB_MAX_SRC; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_rr_ptr, wrapping.
// Produces a one-hot grant, or all zeros when nobody requests.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant
);

  logic        w_found;
  int unsigned w_pos;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      w_pos = (32'(i_rr_ptr) + off) % NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!w_found && (j == w_pos) && i_req[j]) begin
          o_grant[j] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/img_frame_arbiter.sv
// Frame-locked round-robin arbiter in front of the box-filter processor.
// Owner is held from SOF to the last line's tlast; stale non-owner beats are drained.
module img_frame_arbiter
  import img_processing_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned TDATA_WIDTH = AXIS_TDATA_WIDTH,
  parameter int unsigned TUSER_WIDTH = AXIS_TUSER_WIDTH,
  parameter int unsigned FRAME_LINES = IMG_H
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic [NUM_SRC*TDATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]             s_tvalid,
  output logic [NUM_SRC-1:0]             s_tready,
  input  logic [NUM_SRC-1:0]             s_tlast,
  input  logic [NUM_SRC*TUSER_WIDTH-1:0] s_tuser,
  output logic [TDATA_WIDTH-1:0]         m_tdata,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic                           m_tlast,
  output logic [TUSER_WIDTH-1:0]         m_tuser,
  output logic [NUM_SRC-1:0]             grant,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           sof_err,
  output logic [15:0]                    drop_cnt
);

  localparam int unsigned IDX_W  = $clog2(NUM_SRC);
  localparam int unsigned LINE_W = $clog2(FRAME_LINES + 1);
  localparam int unsigned DROP_W = $clog2(ARB_MAX_SRC + 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(FRAME_LINES - 1);

  arb_state_t          r_state, w_next_state;
  logic [NUM_SRC-1:0]  r_grant;
  logic [IDX_W-1:0]    r_owner;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [LINE_W-1:0]   r_line_cnt;
  logic                r_beat_seen;
  logic                r_frame_done;
  logic                r_sof_err;
  logic [15:0]         r_drop_cnt;

  logic [NUM_SRC-1:0]  w_sof, w_req, w_drop, w_arb_grant;
  logic                w_hs, w_sof_mid, w_frame_end;
  logic [LINE_W-1:0]   w_line_base;
  logic [DROP_W-1:0]   w_drop_num;
  logic [16:0]         w_drop_sum;

  always_comb begin
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      w_sof[k] = s_tuser[k*TUSER_WIDTH];
    end
  end

  assign w_req  = s_tvalid & w_sof;
  // Anything headless (no SOF) on a non-owner is stale and gets drained.
  assign w_drop = s_tvalid & ~w_sof & ~r_grant;

  rr_arbiter #(
    .NUM_REQ (NUM_SRC),
    .PTR_W   (IDX_W)
  ) u_rr_arbiter (
    .i_req    (w_req),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_arb_grant)
  );

  assign w_hs        = m_tvalid & m_tready;
  assign w_sof_mid   = w_hs & m_tuser[0] & (r_beat_seen | (r_line_cnt != '0));
  // A mid-frame SOF restarts the count with this beat as line 0.
  assign w_line_base = w_sof_mid ? '0 : r_line_cnt;
  assign w_frame_end = w_hs & m_tlast & (w_line_base == LAST_LINE);

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ARB_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE:   if (enable && (|w_req)) w_next_state = ARB_STREAM;
      ARB_STREAM: if (w_frame_end)        w_next_state = ARB_IDLE;
      default:                            w_next_state = ARB_IDLE;
    endcase
  end

  always_comb begin
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tuser  = '0;
    s_tready = '0;
    busy     = (r_state == ARB_STREAM);
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (r_grant[k]) begin
        m_tdata     = s_tdata[k*TDATA_WIDTH +: TDATA_WIDTH];
        m_tvalid    = s_tvalid[k];
        m_tlast     = s_tlast[k];
        m_tuser     = s_tuser[k*TUSER_WIDTH +: TUSER_WIDTH];
        s_tready[k] = m_tready;
      end else if (w_drop[k]) begin
        s_tready[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_drop_num = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      w_drop_num = w_drop_num + DROP_W'(w_drop[k]);
    end
    w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_num);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_grant      <= '0;
      r_owner      <= '0;
      r_rr_ptr     <= '0;
      r_line_cnt   <= '0;
      r_beat_seen  <= 1'b0;
      r_frame_done <= 1'b0;
      r_sof_err    <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_frame_done <= w_frame_end;
      r_sof_err    <= w_sof_mid;
      r_drop_cnt   <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      if (r_state == ARB_IDLE) begin
        r_line_cnt  <= '0;
        r_beat_seen <= 1'b0;
        if (w_next_state == ARB_STREAM) begin
          r_grant <= w_arb_grant;
          r_owner <= IDX_W'(onehot_to_idx(ARB_MAX_SRC'(w_arb_grant)));
        end
      end else if (w_frame_end) begin
        r_grant    <= '0;
        r_line_cnt <= '0;
        r_rr_ptr   <= (r_owner == IDX_W'(NUM_SRC - 1)) ? '0 : r_owner + 1'b1;
      end else if (w_hs) begin
        r_beat_seen <= 1'b1;
        r_line_cnt  <= m_tlast ? w_line_base + 1'b1 : w_line_base;
      end
    end
  end

  assign grant      = r_grant;
  assign frame_done = r_frame_done;
  assign sof_err    = r_sof_err;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: doc/img_frame_arbiter.md
# img_frame_arbiter

Frame-granular round-robin arbiter that shares the single 3x3 box-filter image processor between up to NUM_SRC AXI-Stream video sources. It sits directly upstream of the processor's slave port. Grants are locked for a whole frame, from the start-of-frame beat until the IMG_H-th tlast, so the processor's line buffers never see interleaved frames. It also drops stale mid-frame beats from non-granted sources so each source resynchronises on its next start-of-frame.

## Interface
- NUM_SRC, 2, number of requesting sources, 2..8
- TDATA_WIDTH, AXIS_TDATA_WIDTH, pixel width per source
- TUSER_WIDTH, AXIS_TUSER_WIDTH, tuser width; bit 0 is start-of-frame (SOF)
- FRAME_LINES, IMG_H, tlast beats that make up one frame
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- enable  in  1  allow new grants; a frame already in progress always completes
- s_tdata  in  NUM_SRC*TDATA_WIDTH  source data, source k at slice k
- s_tvalid  in  NUM_SRC  per-source valid
- s_tready  out  NUM_SRC  per-source ready
- s_tlast  in  NUM_SRC  per-source end-of-line
- s_tuser  in  NUM_SRC*TUSER_WIDTH  per-source tuser
- m_tdata  out  TDATA_WIDTH  to processor
- m_tvalid  out  1  to processor
- m_tready  in  1  from processor
- m_tlast  out  1  to processor
- m_tuser  out  TUSER_WIDTH  to processor
- grant  out  NUM_SRC  one-hot current owner; 0 when idle
- busy  out  1  high while in STREAM
- frame_done  out  1  one-cycle pulse on the final handshake of a frame
- sof_err  out  1  one-cycle pulse on an SOF from the granted source mid-frame
- drop_cnt  out  16  beats discarded for resync; saturates at 0xFFFF

## Operation
- States: IDLE, STREAM.
- Source k requests when s_tvalid[k] & s_tuser[k*TUSER_WIDTH] = 1, meaning an SOF is at its head.
- IDLE:
  - If enable = 1 and any source requests, grant the first requester at or after rr_ptr (wrapping) and go to STREAM.
  - Set line_cnt = 0.
  - No data passes in the arbitration cycle.
- STREAM (owner g):
  - Combinational pass-through: m_t* = s_t*[g] and s_tready[g] = m_tready.
  - On each handshake with tlast, line_cnt increments.
  - On the handshake with tlast when line_cnt = FRAME_LINES-1:
    - pulse frame_done;
    - set rr_ptr = (g+1) mod NUM_SRC;
    - go to IDLE.
- Mid-frame SOF from the owner, i.e. a handshake with tuser[0] = 1 when line_cnt != 0 or after the first beat:
  - pass the beat through;
  - pulse sof_err;
  - reset line_cnt to 0 (the frame restarts);
  - the grant is kept.
- Resync drop:
  - In any state, a non-owner k with s_tvalid[k] = 1 and SOF = 0 gets s_tready[k] = 1 and the beat is discarded.
  - drop_cnt increments by one per dropped beat.
  - If several sources drop in one cycle, drop_cnt increments by the number of sources dropping that cycle (popcount), saturating.
  - A non-owner holding an SOF gets s_tready = 0 and waits.
- The enable deassert is sampled only in IDLE.
- line_cnt width is $clog2(FRAME_LINES+1).

## Timing
- Reset values:
  - state IDLE, grant 0, rr_ptr 0, line_cnt 0;
  - m_tvalid 0, m_tlast 0, m_tuser 0, m_tdata 0;
  - s_tready 0, busy 0, frame_done 0, sof_err 0, drop_cnt 0.
- Reset mid-frame abandons the frame; outputs take reset values the next cycle.
- Data path latency is 0 cycles (combinational mux). grant and state are registered.
- Grant latency: with an SOF present in IDLE, grant asserts 1 cycle later and the first beat can transfer in that cycle.
- Between frames there is exactly one idle cycle (the arbitration cycle), even with back-to-back requesters.
- The owner's tvalid may drop mid-frame and m_tvalid follows it. The grant is never released on a tvalid gap.
- m_tvalid must not depend on m_tready.
- frame_done and sof_err are registered and pulse the cycle after the causing handshake.
- drop_cnt updates the cycle after the drop.

## Structure
- Add to img_processing_pkg:
  - typedef enum arb_state_t {ARB_IDLE, ARB_STREAM};
  - localparam ARB_MAX_SRC = 8.
- Reuse IMG_H, AXIS_TDATA_WIDTH and AXIS_TUSER_WIDTH from the package.
- Sub-module rr_arbiter (NUM_REQ): request vector plus rr_ptr in, one-hot grant out. It is purely combinational priority rotation and is instantiated once.
- The top level holds the FSM, line counter, mux, drop logic and status counters.

## Test plan
- Two sources each send one FRAME_LINES x IMG_W frame with SOF on the same cycle:
  - src0 is granted first, src1 follows after one idle cycle;
  - frame_done pulses twice;
  - output pixels match each source unmixed.
- Round-robin fairness: both sources stream continuous frames for 6 frames. Expected grant order is 0,1,0,1,0,1.
- src1 asserts 5 non-SOF beats while src0 owns the bus:
  - all 5 are dropped with s_tready[1] = 1;
  - drop_cnt = 5;
  - src0's stream is undisturbed.
- Owner sends SOF on line 3:
  - sof_err pulses once;
  - frame_done arrives only after FRAME_LINES further tlasts.
- Random m_tready backpressure (50%) on one frame: output beat sequence is identical to the no-backpressure run, and no beats are lost or duplicated.
- Corner cases:
  - enable = 0 with pending SOF: grant stays 0;
  - reset_n pulsed mid-frame: grant = 0 and m_tvalid = 0 the next cycle, and drop_cnt = 0.
